core_seq_ctrl: RTL and testbench
================================

# core_seq_ctrl

Multi-cycle sequencer for the RV32I core. It is the successor to the single-cycle core, where every instruction completes in one clock against zero-latency memories. The block sits between the decoder, the datapath and the two memory ports. It latches the instruction register and runs each instruction through FETCH/DECODE/EXECUTE/MEM/WB with ready/valid waits on instruction and data memory. It gates the register-file, data-memory and PC write strobes, detects memory timeouts and illegal opcodes, and keeps cycle and retired-instruction counters.

## Interface
- `XLEN`, default 32: instruction/IR width.
- `CNT_W`, default 32: width of `cycle_cnt` and `instret_cnt`.
- `MEM_TIMEOUT`, default 16: maximum wait cycles in FETCH or MEM; 0 disables the timeout.
- `NOP_INSTR`, default 32'h0000_0013: reset value of `ir` (`addi x0,x0,0`).

- `clk` in 1: core clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `machineCode` in XLEN: instruction-memory read data.
- `imem_rvalid` in 1: `machineCode` valid this cycle.
- `dmem_ready` in 1: data access completes this cycle.
- `regFile_wr_en_dec` in 1: decoder register-write request for `ir`.
- `mem_rd_dec` in 1: `ir` is a load.
- `mem_wr_dec` in 1: `ir` is a store.
- `illegal_dec` in 1: `ir` opcode not decodable.
- `ir` out XLEN: latched instruction; drives the decoder and datapath.
- `imem_req` out 1: fetch request.
- `dmem_req` out 1: data access request.
- `dataMem_wr_en` out 1: store strobe.
- `regFile_wr_en` out 1: gated register-file write.
- `pc_en` out 1: PC update strobe.
- `state` out 3: current state, for debug.
- `halted` out 1: core stopped.
- `halt_cause` out 2: 0 none, 1 illegal, 2 dmem timeout, 3 imem timeout.
- `cycle_cnt` out CNT_W: cycle counter.
- `instret_cnt` out CNT_W: retired-instruction counter.

## Operation
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - `imem_req`=1.
  - On `imem_rvalid`: `ir`<=`machineCode`, next state DECODE.
  - Otherwise wait, subject to the timeout rule.
- DECODE: one cycle. If `illegal_dec`, go to HALT with cause 1; otherwise go to EXECUTE.
- EXECUTE: one cycle. If `mem_rd_dec` or `mem_wr_dec`, go to MEM; otherwise go to WB.
- MEM:
  - `dmem_req`=1 and `dataMem_wr_en`=`mem_wr_dec`, both held until `dmem_ready`.
  - On `dmem_ready`, go to WB. The store commits on that edge.
- WB: one cycle.
  - `regFile_wr_en`=`regFile_wr_en_dec` and `pc_en`=1.
  - `instret_cnt` increments.
  - Next state FETCH.
- HALT:
  - All strobes are 0, `halted`=1, and `ir` and `halt_cause` are held.
  - The block stays in HALT until `reset`.
- `regFile_wr_en`, `pc_en`, `dmem_req`, `dataMem_wr_en` and `imem_req` are combinational from state and decode inputs. They are never asserted outside the states listed above.
- `imem_rvalid` outside FETCH and `dmem_ready` outside MEM are ignored.
- Timeout rule:
  - `wait_cnt` clears on entry to FETCH or MEM and increments on each cycle in that state without the handshake.
  - If `MEM_TIMEOUT`≠0 and `wait_cnt`==`MEM_TIMEOUT`-1 with no handshake, go to HALT with cause 3 (FETCH) or 2 (MEM).
  - A handshake on that same cycle wins and completes normally.
- Counters:
  - `cycle_cnt` increments every cycle while not in reset and not halted.
  - Both counters wrap modulo 2^CNT_W and do not saturate.

## Timing
- Reset values:
  - `state`=FETCH, `ir`=`NOP_INSTR`.
  - `halted`=0, `halt_cause`=0.
  - Both counters 0, `wait_cnt`=0.
  - All strobes 0 except `imem_req`=1, which is combinational in FETCH.
- `reset` asserted in any state, including mid-MEM with a store pending, returns to FETCH on the next edge. No strobe is asserted in the reset cycle.
- CPI with zero-wait memories:
  - ALU/branch/jump: 4 (F,D,E,WB).
  - Load/store: 5 (F,D,E,M,WB).
  - Each FETCH or MEM wait cycle adds 1.
- `ir` updates on the edge that leaves FETCH and is stable from DECODE through WB.
- `instret_cnt` increments on the edge that leaves WB, one count per retired instruction. Halted instructions do not retire.

## Test plan
- Reset, then an ALU instruction (`regFile_wr_en_dec`=1) with `imem_rvalid` high → states 0,1,2,4,0. `regFile_wr_en`=`pc_en`=1 only in cycle 4. `instret_cnt`=1, `cycle_cnt`=4.
- Store with `dmem_ready` delayed 3 cycles → `dataMem_wr_en`=`dmem_req`=1 for exactly 4 cycles. `regFile_wr_en`=0 in WB. Total 8 cycles.
- `MEM_TIMEOUT`=16, load with `dmem_ready` never asserted → HALT after exactly 16 MEM cycles, `halt_cause`=2. `cycle_cnt` is then frozen. `dmem_ready` arriving on MEM cycle 16 instead → normal retire.
- `illegal_dec`=1 in DECODE → HALT with `halt_cause`=1, `ir` unchanged, `instret_cnt` unchanged. Reset then restarts in FETCH with `ir`=0x0000_0013.
- `CNT_W`=4: retire 17 ALU instructions → `instret_cnt`=1, `cycle_cnt`=68 mod 16=4.
- Reset asserted during a MEM wait → next cycle `state`=FETCH, `dataMem_wr_en`=0, `halted`=0, both counters 0. `dmem_ready` pulsing in FETCH has no effect.

Source files
------------

// File: rtl/core_seq_ctrl_if.sv
// Memory-side handshake bundle for the multi-cycle sequencer:
// instruction fetch and data access request/response signals.
interface core_seq_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic            imem_rvalid;
  logic [XLEN-1:0] machineCode;
  logic            dmem_req;
  logic            dmem_ready;
  logic            dataMem_wr_en;

  modport master (
    output imem_req,
    output dmem_req,
    output dataMem_wr_en,
    input  imem_rvalid,
    input  machineCode,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dataMem_wr_en,
    output imem_rvalid,
    output machineCode,
    output dmem_ready
  );
endinterface

// File: rtl/core_seq_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WB with
// memory wait timeouts, illegal-opcode halt and perf counters.
module core_seq_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 32,
  parameter int              MEM_TIMEOUT = 16,
  parameter logic [XLEN-1:0] NOP_INSTR   = XLEN'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             reset,
  core_seq_ctrl_if.master  mem,
  input  logic             regFile_wr_en_dec,
  input  logic             mem_rd_dec,
  input  logic             mem_wr_dec,
  input  logic             illegal_dec,
  output logic [XLEN-1:0]  ir,
  output logic             regFile_wr_en,
  output logic             pc_en,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_e;

  localparam int WW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST =
    WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit TO_EN = (MEM_TIMEOUT != 0);

  localparam logic [1:0] C_ILLEGAL = 2'd1;
  localparam logic [1:0] C_DMEM_TO = 2'd2;
  localparam logic [1:0] C_IMEM_TO = 2'd3;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             to_hit;
  logic             run;

  assign to_hit = TO_EN && (wait_q == WAIT_LAST);
  assign run    = !reset;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = '0;
    cause_d   = cause_q;
    halted_d  = halted_q;
    instret_d = instret_q;
    cycle_d   = halted_q ? cycle_q : cycle_q + CNT_W'(1);
    unique case (state_q)
      S_FETCH: begin
        if (mem.imem_rvalid) begin
          ir_d    = mem.machineCode;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d  = S_HALT;
          cause_d  = C_IMEM_TO;
          halted_d = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DECODE: begin
        if (illegal_dec) begin
          state_d  = S_HALT;
          cause_d  = C_ILLEGAL;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = (mem_rd_dec || mem_wr_dec) ? S_MEM : S_WB;
      end
      S_MEM: begin
        // a handshake on the last allowed cycle still completes
        if (mem.dmem_ready) begin
          state_d = S_WB;
        end else if (to_hit) begin
          state_d  = S_HALT;
          cause_d  = C_DMEM_TO;
          halted_d = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WB: begin
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= NOP_INSTR;
      wait_q    <= '0;
      cause_q   <= '0;
      halted_q  <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      halted_q  <= halted_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // strobes are suppressed during the reset cycle itself
  assign mem.imem_req      = run && (state_q == S_FETCH);
  assign mem.dmem_req      = run && (state_q == S_MEM);
  assign mem.dataMem_wr_en = run && (state_q == S_MEM) && mem_wr_dec;
  assign regFile_wr_en     = run && (state_q == S_WB) && regFile_wr_en_dec;
  assign pc_en             = run && (state_q == S_WB);

  assign ir          = ir_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign halt_cause  = cause_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: per-cycle vector table plus
// hand-written timeout, reset and counter-wrap sequences.
module tb_core_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic rf_dec, rd_dec, wr_dec, ill_dec;

  core_seq_ctrl_if #(.XLEN(32)) mif_a ();
  core_seq_ctrl_if #(.XLEN(32)) mif_b ();

  logic [31:0] ir_a, ir_b;
  logic        rfwe_a, pce_a, halted_a;
  logic        rfwe_b, pce_b, halted_b;
  logic [2:0]  state_a, state_b;
  logic [1:0]  cause_a, cause_b;
  logic [31:0] cyc_a, inst_a;
  logic [3:0]  cyc_b, inst_b;

  core_seq_ctrl #(
    .XLEN(32), .CNT_W(32), .MEM_TIMEOUT(16)
  ) dut_a (
    .clk               (clk),
    .reset             (rst_a),
    .mem               (mif_a.master),
    .regFile_wr_en_dec (rf_dec),
    .mem_rd_dec        (rd_dec),
    .mem_wr_dec        (wr_dec),
    .illegal_dec       (ill_dec),
    .ir                (ir_a),
    .regFile_wr_en     (rfwe_a),
    .pc_en             (pce_a),
    .state             (state_a),
    .halted            (halted_a),
    .halt_cause        (cause_a),
    .cycle_cnt         (cyc_a),
    .instret_cnt       (inst_a)
  );

  core_seq_ctrl #(
    .XLEN(32), .CNT_W(4), .MEM_TIMEOUT(16)
  ) dut_b (
    .clk               (clk),
    .reset             (rst_b),
    .mem               (mif_b.master),
    .regFile_wr_en_dec (1'b1),
    .mem_rd_dec        (1'b0),
    .mem_wr_dec        (1'b0),
    .illegal_dec       (1'b0),
    .ir                (ir_b),
    .regFile_wr_en     (rfwe_b),
    .pc_en             (pce_b),
    .state             (state_b),
    .halted            (halted_b),
    .halt_cause        (cause_b),
    .cycle_cnt         (cyc_b),
    .instret_cnt       (inst_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // in = {imem_rvalid, dmem_ready}; dec = {rf, rd, wr, illegal}
  // ex = {imem_req, dmem_req, we, rf_we, pc_en, halted}
  typedef struct {
    logic [1:0]  in;
    logic [31:0] code;
    logic [3:0]  dec;
    logic [2:0]  st;
    logic [5:0]  ex;
    logic [31:0] ir;
  } vec_t;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A   = 32'h0050_0093;
  localparam logic [31:0] S   = 32'h0011_2023;
  localparam logic [31:0] L   = 32'h0001_2083;
  localparam logic [31:0] I   = 32'hFFFF_FFFF;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  vec_t tbl [22];

  function automatic logic [5:0] strobes_a();
    return {mif_a.imem_req, mif_a.dmem_req, mif_a.dataMem_wr_en,
            rfwe_a, pce_a, halted_a};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_a = 1'b1;
    mif_a.imem_rvalid = 1'b0;
    mif_a.dmem_ready  = 1'b0;
    {rf_dec, rd_dec, wr_dec, ill_dec} = 4'b0000;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  int n;

  initial begin
    tbl[0]  = '{2'b10, A,   4'b1000, 3'd0, 6'b100000, NOP};
    tbl[1]  = '{2'b11, BAD, 4'b1000, 3'd1, 6'b000000, A};
    tbl[2]  = '{2'b11, BAD, 4'b1000, 3'd2, 6'b000000, A};
    tbl[3]  = '{2'b01, BAD, 4'b1000, 3'd4, 6'b000110, A};
    tbl[4]  = '{2'b10, S,   4'b0010, 3'd0, 6'b100000, A};
    tbl[5]  = '{2'b01, BAD, 4'b0010, 3'd1, 6'b000000, S};
    tbl[6]  = '{2'b01, BAD, 4'b0010, 3'd2, 6'b000000, S};
    tbl[7]  = '{2'b00, BAD, 4'b0010, 3'd3, 6'b011000, S};
    tbl[8]  = '{2'b10, BAD, 4'b0010, 3'd3, 6'b011000, S};
    tbl[9]  = '{2'b00, BAD, 4'b0010, 3'd3, 6'b011000, S};
    tbl[10] = '{2'b01, BAD, 4'b0010, 3'd3, 6'b011000, S};
    tbl[11] = '{2'b00, BAD, 4'b0010, 3'd4, 6'b000010, S};
    tbl[12] = '{2'b00, L,   4'b1100, 3'd0, 6'b100000, S};
    tbl[13] = '{2'b10, L,   4'b1100, 3'd0, 6'b100000, S};
    tbl[14] = '{2'b00, BAD, 4'b1100, 3'd1, 6'b000000, L};
    tbl[15] = '{2'b00, BAD, 4'b1100, 3'd2, 6'b000000, L};
    tbl[16] = '{2'b01, BAD, 4'b1100, 3'd3, 6'b010000, L};
    tbl[17] = '{2'b00, BAD, 4'b1100, 3'd4, 6'b000110, L};
    tbl[18] = '{2'b10, I,   4'b0001, 3'd0, 6'b100000, L};
    tbl[19] = '{2'b00, BAD, 4'b0001, 3'd1, 6'b000000, I};
    tbl[20] = '{2'b10, NOP, 4'b0001, 3'd5, 6'b000001, I};
    tbl[21] = '{2'b11, A,   4'b1000, 3'd5, 6'b000001, I};

    rst_a = 1'b1;
    rst_b = 1'b1;
    mif_a.imem_rvalid = 1'b0;
    mif_a.dmem_ready  = 1'b0;
    mif_a.machineCode = '0;
    mif_b.imem_rvalid = 1'b1;
    mif_b.dmem_ready  = 1'b0;
    mif_b.machineCode = A;
    {rf_dec, rd_dec, wr_dec, ill_dec} = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;

    #1;
    chk("reset state", 32'(state_a), 32'd0);
    chk("reset ir", ir_a, NOP);
    chk("reset strobes", 32'(strobes_a()), 32'b100000);
    chk("reset cause", 32'(cause_a), 32'd0);
    chk("reset cycle_cnt", cyc_a, 32'd0);
    chk("reset instret", inst_a, 32'd0);

    for (int i = 0; i < 22; i++) begin
      {mif_a.imem_rvalid, mif_a.dmem_ready} = tbl[i].in;
      mif_a.machineCode = tbl[i].code;
      {rf_dec, rd_dec, wr_dec, ill_dec} = tbl[i].dec;
      #1;
      chk($sformatf("row%0d state", i), 32'(state_a), 32'(tbl[i].st));
      chk($sformatf("row%0d strobes", i), 32'(strobes_a()),
          32'(tbl[i].ex));
      chk($sformatf("row%0d ir", i), ir_a, tbl[i].ir);
      if (i == 4) begin
        chk("alu instret", inst_a, 32'd1);
        chk("alu cycles", cyc_a, 32'd4);
      end
      if (i == 12) begin
        chk("store instret", inst_a, 32'd2);
        chk("store cycles", cyc_a, 32'd12);
      end
      if (i == 18) chk("load instret", inst_a, 32'd3);
      @(negedge clk);
    end
    chk("illegal cause", 32'(cause_a), 32'd1);
    chk("illegal instret", inst_a, 32'd3);
    chk("halt cycle freeze", cyc_a, 32'd20);

    do_reset();
    #1;
    chk("restart state", 32'(state_a), 32'd0);
    chk("restart ir", ir_a, NOP);
    chk("restart halted", 32'(halted_a), 32'd0);

    // load whose data port never answers
    mif_a.imem_rvalid = 1'b1;
    mif_a.machineCode = L;
    {rf_dec, rd_dec, wr_dec, ill_dec} = 4'b1100;
    @(negedge clk);
    mif_a.imem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (state_a != 3'd3) break;
      n++;
      @(negedge clk);
    end
    chk("dmem timeout cycles", 32'(n), 32'd16);
    chk("dmem timeout state", 32'(state_a), 32'd5);
    chk("dmem timeout cause", 32'(cause_a), 32'd2);
    chk("dmem timeout cycle_cnt", cyc_a, 32'd19);
    mif_a.dmem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("frozen cycle_cnt", cyc_a, 32'd19);
    chk("halt strobes", 32'(strobes_a()), 32'b000001);

    // ready arrives on the last allowed MEM cycle
    do_reset();
    mif_a.imem_rvalid = 1'b1;
    mif_a.machineCode = L;
    {rf_dec, rd_dec, wr_dec, ill_dec} = 4'b1100;
    @(negedge clk);
    mif_a.imem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      mif_a.dmem_ready = (k == 16);
      #1;
      chk($sformatf("late mem%0d state", k), 32'(state_a), 32'd3);
      @(negedge clk);
    end
    mif_a.dmem_ready = 1'b0;
    #1;
    chk("late ready wb", 32'(state_a), 32'd4);
    chk("late ready halted", 32'(halted_a), 32'd0);
    @(negedge clk);
    #1;
    chk("late ready instret", inst_a, 32'd1);
    chk("late ready cause", 32'(cause_a), 32'd0);

    // instruction memory never answers
    do_reset();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (state_a != 3'd0) break;
      n++;
      @(negedge clk);
    end
    chk("imem timeout cycles", 32'(n), 32'd16);
    chk("imem timeout cause", 32'(cause_a), 32'd3);

    // reset while a store waits in MEM
    do_reset();
    mif_a.imem_rvalid = 1'b1;
    mif_a.machineCode = S;
    {rf_dec, rd_dec, wr_dec, ill_dec} = 4'b0010;
    @(negedge clk);
    mif_a.imem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid-mem we", 32'(mif_a.dataMem_wr_en), 32'd1);
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("reset-cycle strobes", 32'(strobes_a()), 32'b000000);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("post-reset state", 32'(state_a), 32'd0);
    chk("post-reset we", 32'(mif_a.dataMem_wr_en), 32'd0);
    chk("post-reset halted", 32'(halted_a), 32'd0);
    chk("post-reset counters", cyc_a | inst_a, 32'd0);
    for (int k = 0; k < 3; k++) begin
      mif_a.dmem_ready = 1'b1;
      @(negedge clk);
      mif_a.dmem_ready = 1'b0;
      #1;
      chk($sformatf("fetch ready pulse%0d", k), 32'(state_a), 32'd0);
      chk($sformatf("fetch dmem_req%0d", k), 32'(mif_a.dmem_req),
          32'd0);
    end

    // narrow counters wrap
    @(negedge clk);
    rst_b = 1'b0;
    repeat (68) @(negedge clk);
    #1;
    chk("wrap instret", 32'(inst_b), 32'd1);
    chk("wrap cycle_cnt", 32'(cyc_b), 32'd4);
    chk("wrap state", 32'(state_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
